// File: rtl/jedro_1_pkg.sv
//------------------------------------------------------------------------------
// Module      : jedro_1_pkg
// Description : Shared types and helpers for the jedro_1 memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jedro_1_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_e;

    localparam int MEM_BE_WIDTH = 4;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jedro_1_arb_select.sv
//------------------------------------------------------------------------------
// Module      : jedro_1_arb_select
// Description : Winner selection between fetch and data requesters, with
//               starvation counter (default) or round-robin (JEDRO_1_ARB_RR_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jedro_1_arb_select
    import jedro_1_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       if_req_i,
    input  logic       d_req_i,
    output logic [1:0] gnt_o
);

    logic w_if_wins;

`ifdef JEDRO_1_ARB_RR_EN
    // 1 = data was granted most recently; resets to fetch so data wins first
    logic r_last_d;

    assign w_if_wins = r_last_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_d <= 1'b0;
        end else if (|gnt_o) begin
            r_last_d <= gnt_o[GNT_D];
        end
    end
`else
    localparam int CW = wait_cnt_width(MAX_WAIT);

    logic [CW-1:0] r_wait_cnt;

    assign w_if_wins = (r_wait_cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wait_cnt <= '0;
        end else if (!if_req_i || gnt_o[GNT_IF]) begin
            r_wait_cnt <= '0;
        end else if (!w_if_wins) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end
`endif

    // Priority only matters on a conflict; a lone requester always wins
    always_comb begin
        gnt_o = 2'b00;
        if (rstn_i) begin
            if (if_req_i && (!d_req_i || w_if_wins)) begin
                gnt_o[GNT_IF] = 1'b1;
            end else if (d_req_i) begin
                gnt_o[GNT_D] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jedro_1_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : jedro_1_mem_arbiter
// Description : Shares one 1-cycle-latency single-port RAM between the jedro_1
//               fetch and data masters. Define JEDRO_1_ARB_RR_EN for round-robin.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jedro_1_mem_arbiter
    import jedro_1_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [MEM_BE_WIDTH-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    mem_en_o,
    output logic [MEM_BE_WIDTH-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    logic [1:0]  w_gnt;
    resp_owner_e r_resp;
    resp_owner_e w_resp_nxt;

    jedro_1_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb_select (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .gnt_o    (w_gnt)
    );

    assign if_gnt_o    = w_gnt[GNT_IF];
    assign d_gnt_o     = w_gnt[GNT_D];

    assign mem_en_o    = |w_gnt;
    assign mem_we_o    = (d_gnt_o && d_we_i) ? d_be_i : '0;
    assign mem_addr_o  = d_gnt_o ? d_addr_i : if_addr_i;
    assign mem_wdata_o = d_wdata_i;

    // Remember who owns the RAM output on the next cycle
    always_comb begin
        w_resp_nxt = RESP_NONE;
        if (w_gnt[GNT_IF]) begin
            w_resp_nxt = RESP_IF;
        end else if (w_gnt[GNT_D]) begin
            w_resp_nxt = RESP_D;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_resp <= RESP_NONE;
        end else begin
            r_resp <= w_resp_nxt;
        end
    end

    assign if_rvalid_o = (r_resp == RESP_IF);
    assign d_rvalid_o  = (r_resp == RESP_D);
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_jedro_1_mem_arbiter
// Description : Self-checking bench for jedro_1_mem_arbiter against a
//               transaction-level model (honours JEDRO_1_ARB_RR_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jedro_1_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h000010b7;
            1:       return 32'h00002137;
            2:       return 32'h000031b7;
            64:      return 32'h12345678;
            default: return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // RAM: samples the port mid-cycle, acts on the rising edge
    logic [31:0] ram [0:255];
    initial begin
        logic        en;
        logic [3:0]  we;
        logic [7:0]  idx;
        logic [31:0] wd;
        mem_rdata_i = '0;
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        forever begin
            @(negedge clk_i);
            #3;
            en  = mem_en_o;
            we  = mem_we_o;
            idx = mem_addr_o[9:2];
            wd  = mem_wdata_o;
            @(posedge clk_i);
            if (en) begin
                mem_rdata_i <= ram[idx];
                for (int b = 0; b < 4; b++)
                    if (we[b]) ram[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference model
    logic [31:0] shadow [0:255];
    int          streak;       // consecutive cycles the fetch waited
    bit          last_was_d;   // most recent winner was the data master
    bit          exp_rv_if, exp_rv_d, exp_rdata_chk;
    logic [31:0] exp_rdata;
    bit          g_if, g_d;

    task automatic model_reset();
        streak        = 0;
        last_was_d    = 1'b0;
        exp_rv_if     = 1'b0;
        exp_rv_d      = 1'b0;
        exp_rdata_chk = 1'b0;
    endtask

    // Called just after the falling edge once inputs are applied
    task automatic cycle();
        bit          e_if, e_d;
        logic [7:0]  idx;
        logic [31:0] addr;
        #1;
        check("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, exp_rv_if});
        check("d_rvalid",  {31'b0, d_rvalid_o},  {31'b0, exp_rv_d});
        if (exp_rv_if) check("if_rdata", if_rdata_o, exp_rdata);
        if (exp_rv_d && exp_rdata_chk) check("d_rdata", d_rdata_o, exp_rdata);

        e_if = 1'b0;
        e_d  = 1'b0;
        if (if_req_i && !d_req_i) e_if = 1'b1;
        else if (d_req_i && !if_req_i) e_d = 1'b1;
        else if (if_req_i && d_req_i) begin
`ifdef JEDRO_1_ARB_RR_EN
            e_if = last_was_d;
`else
            e_if = (streak >= MAX_WAIT);
`endif
            e_d = !e_if;
        end
        check("if_gnt", {31'b0, if_gnt_o}, {31'b0, e_if});
        check("d_gnt",  {31'b0, d_gnt_o},  {31'b0, e_d});
        check("mem_en", {31'b0, mem_en_o}, {31'b0, (e_if | e_d)});
        addr = e_d ? d_addr_i : if_addr_i;
        if (e_if || e_d) begin
            check("mem_addr", mem_addr_o, addr);
            check("mem_we", {28'b0, mem_we_o}, {28'b0, ((e_d && d_we_i) ? d_be_i : 4'b0)});
            if (e_d && d_we_i) check("mem_wdata", mem_wdata_o, d_wdata_i);
        end

        idx           = addr[9:2];
        exp_rdata     = shadow[idx];
        exp_rdata_chk = !(e_d && d_we_i);
        if (e_d && d_we_i)
            for (int b = 0; b < 4; b++)
                if (d_be_i[b]) shadow[idx][8*b +: 8] = d_wdata_i[8*b +: 8];
        exp_rv_if = e_if;
        exp_rv_d  = e_d;
        if (if_req_i && !e_if) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
        else streak = 0;
        if (e_if || e_d) last_was_d = e_d;
        g_if = e_if;
        g_d  = e_d;
    endtask

    task automatic set_idle();
        if_req_i  = 1'b0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_be_i    = 4'b0;
    endtask

    initial begin
        int           max_denied, denied;
        bit           exp_d_first;
        logic [31:0]  fetch_words [0:2];
        fetch_words[0] = 32'h000010b7;
        fetch_words[1] = 32'h00002137;
        fetch_words[2] = 32'h000031b7;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        model_reset();

        // Reset state with both requests pending
        rstn_i    = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_be_i    = 4'b0;
        d_addr_i  = 32'h0;
        d_wdata_i = 32'h0;
        #12;
        check("rst_if_gnt", {31'b0, if_gnt_o}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt_o}, 32'd0);
        check("rst_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        set_idle();
        cycle();

        // Conflict: both held for 10 cycles
        max_denied  = 0;
        denied      = 0;
        exp_d_first = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if_req_i = 1'b1; if_addr_i = 32'h10;
            d_req_i  = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
            cycle();
`ifdef JEDRO_1_ARB_RR_EN
            check("rr_pattern", {31'b0, d_gnt_o}, {31'b0, ((i % 2) == 0)});
`else
            check("fp_pattern", {31'b0, d_gnt_o}, {31'b0, ((i % 5) != 4)});
`endif
            if (!if_gnt_o) denied++; else denied = 0;
            if (denied > max_denied) max_denied = denied;
        end
        check("if_starve", {31'b0, (max_denied <= MAX_WAIT)}, {31'b0, exp_d_first});
        @(negedge clk_i); set_idle(); cycle();

        // Fetch only, consecutive words
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if_req_i = 1'b1; if_addr_i = 32'(i * 4);
            cycle();
            check("fetch_gnt", {31'b0, if_gnt_o}, 32'd1);
            if (i > 0) check("fetch_word", if_rdata_o, fetch_words[i-1]);
        end
        @(negedge clk_i); set_idle(); cycle();
        check("fetch_word", if_rdata_o, fetch_words[2]);

        // Partial write then read back
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
        d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
        cycle();
        check("wr_mem_we", {28'b0, mem_we_o}, 32'h3);
        @(negedge clk_i);
        d_we_i = 1'b0; d_be_i = 4'b1111;
        cycle();
        check("wr_ack", {31'b0, d_rvalid_o}, 32'd1);
        @(negedge clk_i); set_idle(); cycle();
        check("rd_merge", d_rdata_o, 32'h1234BEEF);

        // Lone data request while the fetch counter is saturated
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk_i);
            if_req_i = 1'b1; if_addr_i = 32'h40;
            d_req_i  = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h44;
            cycle();
        end
        @(negedge clk_i);
        if_req_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h48;
        cycle();
        check("lone_d_gnt", {31'b0, d_gnt_o}, 32'd1);
        @(negedge clk_i); set_idle(); cycle();
        check("lone_no_if", {31'b0, if_rvalid_o}, 32'd0);

        // Randomized traffic, requesters hold until granted
        g_if = 1'b1;
        g_d  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (!(if_req_i && !g_if)) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = {22'b0, 8'($urandom), 2'b00};
            end
            if (!(d_req_i && !g_d)) begin
                d_req_i   = ($urandom_range(0, 2) != 0);
                d_we_i    = $urandom_range(0, 1) == 1;
                d_be_i    = 4'($urandom);
                d_addr_i  = {22'b0, 8'($urandom), 2'b00};
                d_wdata_i = $urandom;
            end
            cycle();
        end
        @(negedge clk_i); set_idle(); cycle();

        // Reset lands after the grant, before the response edge
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        cycle();
        #1 rstn_i = 1'b0;
        #1;
        check("rst_gnt_drop", {31'b0, d_gnt_o}, 32'd0);
        @(posedge clk_i); #1;
        check("rst_no_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1; set_idle(); model_reset();
        cycle();
        check("rst_no_replay", {31'b0, d_rvalid_o}, 32'd0);

        // Reset while the response is already visible
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8;
        cycle();
        @(posedge clk_i); #1;
        check("pre_rst_rvalid", {31'b0, d_rvalid_o}, 32'd1);
        rstn_i = 1'b0;
        #1;
        check("async_rvalid", {31'b0, d_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1; set_idle(); model_reset();
        cycle();
        @(negedge clk_i); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/jedro_1_mem_arbiter.md
Name: jedro_1_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the jedro_1 instruction-fetch master and the data (load/store) master.
- The RAM has a fixed 1-cycle read latency.
- Per cycle, the block selects one requester, drives the RAM port, and routes the response back one cycle later.
- Sits between jedro_1_top's instruction/data memory interfaces and a unified memory, so the core runs on a single-RAM FPGA build.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the RAM port.
- DATA_WIDTH, 32, data width. Must be 32, giving 4 byte enables.
- MAX_WAIT, 4, consecutive cycles the instruction requester may be denied before it is forced to win (fixed-priority mode only). Range 1..15.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset
- if_req_i  in  1  instruction fetch request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DATA_WIDTH  fetch read data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write
- d_be_i  in  4  byte enables
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  write data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response (read data, or write ack)
- d_rdata_o  out  DATA_WIDTH  data read data
- mem_en_o  out  1  RAM enable
- mem_we_o  out  4  RAM byte write enables
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_en_o

Interface (already decided): one clock, clk_i; reset rstn_i is asynchronous and active-low.

Behaviour:
- Grant is combinational in the request cycle. At most one of if_gnt_o / d_gnt_o is high per cycle.
- A gnt is only asserted while the corresponding req is high.
- Requesters hold req and address/data stable until granted.
- mem_en_o = if_gnt_o | d_gnt_o. The address mux follows the granted requester.
- mem_we_o = d_be_i when d_gnt_o & d_we_i, else 4'b0000. An instruction grant never writes.
- Response owner register resp_q has states NONE / IF / D:
  - Next value is IF on if_gnt_o, D on d_gnt_o, otherwise NONE.
  - if_rvalid_o = (resp_q == IF); d_rvalid_o = (resp_q == D).
- Latency: grant in cycle N, then rvalid and data in cycle N+1.
- Back-to-back grants are allowed every cycle, with no bubble.
- if_rdata_o and d_rdata_o both pass mem_rdata_i straight through. Each is valid only while its rvalid is high.
- Writes also return d_rvalid_o one cycle later. d_rdata_o is don't-care on a write response.
- Fixed-priority arbitration (default, macro absent):
  - Data wins any conflict.
  - wait_cnt increments each cycle if_req_i is high and not granted, and clears on an instruction grant or when if_req_i is low.
  - When wait_cnt == MAX_WAIT, the instruction requester wins the next conflict.
  - wait_cnt saturates at MAX_WAIT and never wraps.
- Single requester: granted immediately, regardless of wait_cnt.
- Reset (asynchronous, including mid-transaction):
  - resp_q = NONE, wait_cnt = 0, all rvalid = 0.
  - Any in-flight response is dropped, not replayed.
  - Grants are 0 while rstn_i is low.

Optional Feature:
- Macro: JEDRO_1_ARB_RR_EN.
- Defined:
  - Round-robin arbitration replaces data priority and wait_cnt.
  - A 1-bit last_q register records the last granted requester (reset value = IF, so data wins the first conflict).
  - On a conflict, the requester not in last_q wins. last_q updates on every grant.
  - MAX_WAIT is unused.
- Undefined: fixed priority with starvation counter, as described in Behaviour.

Decomposition:
- jedro_1_pkg holds:
  - enum resp_owner_e {RESP_NONE, RESP_IF, RESP_D}
  - constant MEM_BE_WIDTH = 4
  - function wait_cnt_width(MAX_WAIT) = $clog2(MAX_WAIT+1)
- One sub-module, jedro_1_arb_select: the combinational winner selection plus the wait_cnt / last_q state. It outputs a 2-bit one-hot grant.
- The top level handles the muxes and the response register.

Test Plan:
- Reset checks: assert rstn_i low mid-read (after a grant, before rvalid) -> rvalid outputs 0 immediately, no rvalid after release, resp_q = NONE.
- Fetch only: if_req at 0x0, 0x4, 0x8 on consecutive cycles, RAM preloaded 0x00001_0b7 / 0x00002_137 / 0x00003_1b7 -> if_gnt high 3 cycles, if_rvalid in cycles N+1..N+3 with those words in order.
- Data write then read: d_we=1, be=4'b0011, addr 0x100, wdata 0xDEADBEEF; then read 0x100 over old 0x12345678 -> mem_we_o=4'b0011, write ack next cycle, read returns 0x1234BEEF.
- Fixed-priority conflict: both reqs held high for 10 cycles, MAX_WAIT=4 -> grant pattern D,D,D,D,IF repeating; the fetch is never denied 5 consecutive cycles.
- RR build (JEDRO_1_ARB_RR_EN): both reqs held high for 6 cycles -> D,IF,D,IF,D,IF; each rvalid matches the previous cycle's grant.
- Single requester: d_req alone while wait_cnt = MAX_WAIT -> granted the same cycle, with no IF response.
